// File: rtl/store_buffer_if.sv
// Data-memory port bundle between the store buffer and the memory system.
// The master drives the load request, store request and load-response ready;
// the memory side drives the readies and the load response.
interface dmem_if #(
    parameter int LDTAG_W = 4
);
    logic               ld_valid;
    logic               ld_ready;
    logic [31:0]        ld_addr;
    logic [LDTAG_W-1:0] ld_tag;

    logic               ld_resp_valid;
    logic               ld_resp_ready;
    logic [63:0]        ld_resp_data;
    logic [LDTAG_W-1:0] ld_resp_tag;

    logic               st_valid;
    logic               st_ready;
    logic [31:0]        st_addr;
    logic [63:0]        st_wdata;
    logic [7:0]         st_wstrb;

    modport master (
        output ld_valid, ld_addr, ld_tag, ld_resp_ready,
        output st_valid, st_addr, st_wdata, st_wstrb,
        input  ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag, st_ready
    );

    modport slave (
        input  ld_valid, ld_addr, ld_tag, ld_resp_ready,
        input  st_valid, st_addr, st_wdata, st_wstrb,
        output ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag, st_ready
    );
endinterface

// File: rtl/store_buffer.sv
// Committed-store buffer and load-issue gate.
// Retired stores queue in order and drain one per cycle to dmem; loads that
// overlap any buffered (or same-cycle incoming) store are held back.
// Optional feature macro SB_FWD_EN: forward a load fully covered by exactly
// one buffered store instead of stalling it.
module store_buffer #(
    parameter int SB_DEPTH = 4,
    parameter int LDTAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_in_valid,
    output logic                       st_in_ready,
    input  logic [31:0]                st_in_addr,
    input  logic [63:0]                st_in_data,
    input  logic [7:0]                 st_in_wstrb,
    input  logic                       ld_in_valid,
    output logic                       ld_in_ready,
    input  logic [31:0]                ld_in_addr,
    input  logic [1:0]                 ld_in_size,
    input  logic [LDTAG_W-1:0]         ld_in_tag,
    output logic                       fwd_valid,
    output logic [63:0]                fwd_data,
    output logic [LDTAG_W-1:0]         fwd_tag,
    output logic                       sb_empty,
    output logic [$clog2(SB_DEPTH):0]  sb_count,
    dmem_if.master                     dmem
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             init_q, init_d;
    logic [28:0]      addr_q  [SB_DEPTH];
    logic [28:0]      addr_d  [SB_DEPTH];
    logic [63:0]      data_q  [SB_DEPTH];
    logic [63:0]      data_d  [SB_DEPTH];
    logic [7:0]       wstrb_q [SB_DEPTH];
    logic [7:0]       wstrb_d [SB_DEPTH];

    logic [7:0]          size_mask, lmask;
    logic [PTR_W-1:0]    rel;
    logic [SB_DEPTH-1:0] entry_vld, hit_vec;
    logic                enq, deq, in_hit, conflict, block, fwd_ok;
    logic                unused_ok;

    // Loads are blocked while in reset and on the first cycle after release.
    assign block = rst || init_q;

    assign st_in_ready = !rst && (count_q != CNT_W'(SB_DEPTH));
    assign enq         = st_in_valid && st_in_ready;
    assign deq         = dmem.st_valid && dmem.st_ready;

    assign dmem.st_valid      = !rst && (count_q != '0);
    assign dmem.st_addr       = {addr_q[head_q], 3'b000};
    assign dmem.st_wdata      = data_q[head_q];
    assign dmem.st_wstrb      = wstrb_q[head_q];
    assign dmem.ld_resp_ready = 1'b1;

    assign sb_count = count_q;
    assign sb_empty = (count_q == '0);

    // Byte lanes touched by the incoming load.
    always_comb begin
        case (ld_in_size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        lmask = size_mask << ld_in_addr[2:0];
    end

    // Per-entry validity (position relative to head) and overlap with the load.
    always_comb begin
        rel       = '0;
        entry_vld = '0;
        hit_vec   = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            rel          = PTR_W'(i) - head_q;
            entry_vld[i] = ({1'b0, rel} < count_q);
            hit_vec[i]   = entry_vld[i] && (addr_q[i] == ld_in_addr[31:3])
                           && ((wstrb_q[i] & lmask) != 8'h00);
        end
    end

    assign in_hit   = enq && (st_in_addr[31:3] == ld_in_addr[31:3])
                      && ((st_in_wstrb & lmask) != 8'h00);
    assign conflict = (hit_vec != '0) || in_hit;

    assign dmem.ld_valid = ld_in_valid && !conflict && !block;
    assign dmem.ld_addr  = ld_in_addr;
    assign dmem.ld_tag   = ld_in_tag;
    assign ld_in_ready   = !block && ((dmem.ld_ready && !conflict) || (conflict && fwd_ok));

`ifdef SB_FWD_EN
    logic [CNT_W-1:0]   hit_cnt;
    logic [63:0]        sel_data, byte_mask;
    logic [7:0]         sel_wstrb;
    logic               fwd_valid_q, fwd_valid_d;
    logic [63:0]        fwd_data_q, fwd_data_d;
    logic [LDTAG_W-1:0] fwd_tag_q, fwd_tag_d;

    // Pick the single overlapping entry and decide whether it covers the load.
    always_comb begin
        hit_cnt   = '0;
        sel_data  = '0;
        sel_wstrb = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (hit_vec[i]) begin
                hit_cnt   = hit_cnt + 1'b1;
                sel_data  = data_q[i];
                sel_wstrb = wstrb_q[i];
            end
        end
        for (int b = 0; b < 8; b++) begin
            byte_mask[8*b +: 8] = {8{lmask[b]}};
        end
        fwd_ok = !in_hit && (hit_cnt == CNT_W'(1)) && ((sel_wstrb & lmask) == lmask);
    end

    // Forward response is registered; data and tag hold between forwards.
    always_comb begin
        fwd_valid_d = ld_in_valid && !block && conflict && fwd_ok;
        fwd_data_d  = fwd_data_q;
        fwd_tag_d   = fwd_tag_q;
        if (fwd_valid_d) begin
            fwd_data_d = sel_data & byte_mask;
            fwd_tag_d  = ld_in_tag;
        end
    end

    // Forward response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            fwd_tag_q   <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            fwd_tag_q   <= fwd_tag_d;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_data  = fwd_data_q;
    assign fwd_tag   = fwd_tag_q;
`else
    assign fwd_ok    = 1'b0;
    assign fwd_valid = 1'b0;
    assign fwd_data  = '0;
    assign fwd_tag   = '0;
`endif

    // FIFO next state: write at tail, retire at head, count tracks both.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wstrb_d = wstrb_q;
        init_d  = 1'b0;
        if (enq) begin
            addr_d[tail_q]  = st_in_addr[31:3];
            data_d[tail_q]  = st_in_data;
            wstrb_d[tail_q] = st_in_wstrb;
            tail_d          = tail_q + 1'b1;
        end
        if (deq) begin
            head_d = head_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; entry storage needs no reset since count gates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            init_q  <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            init_q  <= init_d;
        end
        addr_q  <= addr_d;
        data_q  <= data_d;
        wstrb_q <= wstrb_d;
    end

    // Low address bits of stores and the load response are not used here.
    assign unused_ok = ^{st_in_addr[2:0], dmem.ld_resp_valid, dmem.ld_resp_data,
                         dmem.ld_resp_tag, entry_vld};
endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer (default depth 4, tag width 4).
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_in_valid, st_in_ready;
    logic [31:0] st_in_addr;
    logic [63:0] st_in_data;
    logic [7:0]  st_in_wstrb;
    logic        ld_in_valid, ld_in_ready;
    logic [31:0] ld_in_addr;
    logic [1:0]  ld_in_size;
    logic [3:0]  ld_in_tag;
    logic        fwd_valid;
    logic [63:0] fwd_data;
    logic [3:0]  fwd_tag;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int total  = 0;
    int passed = 0;

    dmem_if #(.LDTAG_W(4)) dmem_bus ();

    store_buffer #(.SB_DEPTH(4), .LDTAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .st_in_valid(st_in_valid), .st_in_ready(st_in_ready), .st_in_addr(st_in_addr),
        .st_in_data(st_in_data), .st_in_wstrb(st_in_wstrb),
        .ld_in_valid(ld_in_valid), .ld_in_ready(ld_in_ready), .ld_in_addr(ld_in_addr),
        .ld_in_size(ld_in_size), .ld_in_tag(ld_in_tag),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fwd_tag(fwd_tag),
        .sb_empty(sb_empty), .sb_count(sb_count), .dmem(dmem_bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        st_in_valid = 1'b1; st_in_addr = a; st_in_data = d; st_in_wstrb = s;
        step();
        st_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_in_valid = 0; st_in_addr = 0; st_in_data = 0; st_in_wstrb = 0;
        ld_in_valid = 1'b1; ld_in_addr = 32'h40; ld_in_size = 2'd3; ld_in_tag = 4'h1;
        dmem_bus.st_ready = 1'b0; dmem_bus.ld_ready = 1'b1;
        dmem_bus.ld_resp_valid = 1'b0; dmem_bus.ld_resp_data = '0; dmem_bus.ld_resp_tag = '0;
        step(); step();
        total++; if (st_in_ready !== 1'b0) $display("FAIL rst_st_in_ready got %b exp 0", st_in_ready); else passed++;
        total++; if (ld_in_ready !== 1'b0) $display("FAIL rst_ld_in_ready got %b exp 0", ld_in_ready); else passed++;
        total++; if (dmem_bus.ld_valid !== 1'b0) $display("FAIL rst_ld_valid got %b exp 0", dmem_bus.ld_valid); else passed++;
        total++; if (dmem_bus.st_valid !== 1'b0) $display("FAIL rst_st_valid got %b exp 0", dmem_bus.st_valid); else passed++;
        total++; if (fwd_valid !== 1'b0) $display("FAIL rst_fwd_valid got %b exp 0", fwd_valid); else passed++;
        total++; if ({sb_empty, sb_count} !== 4'b1000) $display("FAIL rst_empty_count got %b/%0d exp 1/0", sb_empty, sb_count); else passed++;
        rst = 1'b0;
        #1;
        total++; if (st_in_ready !== 1'b1) $display("FAIL rel1_st_in_ready got %b exp 1", st_in_ready); else passed++;
        total++; if (ld_in_ready !== 1'b0) $display("FAIL rel1_ld_in_ready got %b exp 0", ld_in_ready); else passed++;
        total++; if (dmem_bus.ld_valid !== 1'b0) $display("FAIL rel1_ld_valid got %b exp 0", dmem_bus.ld_valid); else passed++;
        step();
        total++; if (dmem_bus.ld_valid !== 1'b1) $display("FAIL rel2_ld_valid got %b exp 1", dmem_bus.ld_valid); else passed++;
        ld_in_valid = 1'b0;
    endtask

    task automatic test_fifo_drain();
        dmem_bus.st_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_in_valid = 1'b1; st_in_addr = 32'h100 + 32'(8 * i);
            st_in_data = 64'hA0 + 64'(i); st_in_wstrb = 8'hFF;
            #1;
            total++; if (st_in_ready !== 1'b1) $display("FAIL fill_ready[%0d] got %b exp 1", i, st_in_ready); else passed++;
            step();
        end
        st_in_addr = 32'h120; #1;
        total++; if (sb_count !== 3'd4) $display("FAIL full_count got %0d exp 4", sb_count); else passed++;
        total++; if (st_in_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", st_in_ready); else passed++;
        st_in_valid = 1'b0;
        dmem_bus.st_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (dmem_bus.st_valid !== 1'b1 || dmem_bus.st_addr !== 32'h100 + 32'(8 * i))
                $display("FAIL drain_addr[%0d] got %b/%h exp 1/%h", i, dmem_bus.st_valid, dmem_bus.st_addr, 32'h100 + 32'(8 * i));
            else passed++;
            total++; if (dmem_bus.st_wdata !== 64'hA0 + 64'(i)) $display("FAIL drain_data[%0d] got %h exp %h", i, dmem_bus.st_wdata, 64'hA0 + 64'(i)); else passed++;
            step();
        end
        total++; if (sb_empty !== 1'b1 || dmem_bus.st_valid !== 1'b0) $display("FAIL drained_empty got %b/%b exp 1/0", sb_empty, dmem_bus.st_valid); else passed++;
    endtask

    task automatic test_no_conflict();
        dmem_bus.st_ready = 1'b0;
        put_store(32'h200, 64'h11223344, 8'h0F);
        ld_in_valid = 1'b1; ld_in_addr = 32'h204; ld_in_size = 2'd2; ld_in_tag = 4'h3;
        #1;
        total++; if (dmem_bus.ld_valid !== 1'b1 || ld_in_ready !== 1'b1) $display("FAIL nc_issue got %b/%b exp 1/1", dmem_bus.ld_valid, ld_in_ready); else passed++;
        total++; if (dmem_bus.ld_addr !== 32'h204 || dmem_bus.ld_tag !== 4'h3) $display("FAIL nc_pass got %h/%h exp 204/3", dmem_bus.ld_addr, dmem_bus.ld_tag); else passed++;
        step();
        ld_in_valid = 1'b0;
    endtask

    task automatic test_conflict_stall();
        // Store 0x200/0x0F is still buffered from the previous test.
        ld_in_valid = 1'b1; ld_in_addr = 32'h200; ld_in_tag = 4'h4;
`ifdef SB_FWD_EN
        ld_in_size = 2'd3;
`else
        ld_in_size = 2'd2;
`endif
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (ld_in_ready !== 1'b0 || dmem_bus.ld_valid !== 1'b0) $display("FAIL stall[%0d] got %b/%b exp 0/0", i, ld_in_ready, dmem_bus.ld_valid); else passed++;
            step();
        end
        dmem_bus.st_ready = 1'b1; #1;
        total++; if (ld_in_ready !== 1'b0 || dmem_bus.st_valid !== 1'b1) $display("FAIL stall_deq got %b/%b exp 0/1", ld_in_ready, dmem_bus.st_valid); else passed++;
        step();
        total++; if (dmem_bus.ld_valid !== 1'b1 || ld_in_ready !== 1'b1) $display("FAIL stall_release got %b/%b exp 1/1", dmem_bus.ld_valid, ld_in_ready); else passed++;
        ld_in_valid = 1'b0;
        dmem_bus.st_ready = 1'b0;
    endtask

    task automatic test_forward();
        put_store(32'h200, 64'h11223344, 8'h0F);
        ld_in_valid = 1'b1; ld_in_addr = 32'h202; ld_in_size = 2'd1; ld_in_tag = 4'h5;
        #1;
        total++; if (dmem_bus.ld_valid !== 1'b0) $display("FAIL fwd_no_issue got %b exp 0", dmem_bus.ld_valid); else passed++;
`ifdef SB_FWD_EN
        total++; if (ld_in_ready !== 1'b1) $display("FAIL fwd_ready got %b exp 1", ld_in_ready); else passed++;
        step();
        ld_in_valid = 1'b0;
        total++; if (fwd_valid !== 1'b1 || fwd_tag !== 4'h5) $display("FAIL fwd_resp got %b/%h exp 1/5", fwd_valid, fwd_tag); else passed++;
        total++; if (fwd_data !== 64'h0000_0000_1122_0000) $display("FAIL fwd_data got %h exp 0000000011220000", fwd_data); else passed++;
        step();
        total++; if (fwd_valid !== 1'b0) $display("FAIL fwd_pulse got %b exp 0", fwd_valid); else passed++;
`else
        total++; if (ld_in_ready !== 1'b0) $display("FAIL nofwd_ready got %b exp 0", ld_in_ready); else passed++;
        step();
        ld_in_valid = 1'b0;
        total++; if (fwd_valid !== 1'b0 || fwd_data !== 64'h0) $display("FAIL nofwd_resp got %b/%h exp 0/0", fwd_valid, fwd_data); else passed++;
`endif
        dmem_bus.st_ready = 1'b1; step(); dmem_bus.st_ready = 1'b0;
    endtask

    task automatic test_multi_overlap();
        put_store(32'h300, 64'hAA, 8'h01);
        put_store(32'h300, 64'hBB00, 8'h02);
        ld_in_valid = 1'b1; ld_in_addr = 32'h300; ld_in_size = 2'd1; ld_in_tag = 4'h6;
        #1;
        total++; if (ld_in_ready !== 1'b0 || dmem_bus.ld_valid !== 1'b0) $display("FAIL multi_stall got %b/%b exp 0/0", ld_in_ready, dmem_bus.ld_valid); else passed++;
        step();
        total++; if (fwd_valid !== 1'b0) $display("FAIL multi_nofwd got %b exp 0", fwd_valid); else passed++;
        ld_in_valid = 1'b0;
        dmem_bus.st_ready = 1'b1; step(); step(); dmem_bus.st_ready = 1'b0;
        total++; if (sb_empty !== 1'b1) $display("FAIL multi_drained got %b exp 1", sb_empty); else passed++;
    endtask

    task automatic test_same_cycle_store();
        st_in_valid = 1'b1; st_in_addr = 32'h400; st_in_data = 64'h55; st_in_wstrb = 8'hFF;
        ld_in_valid = 1'b1; ld_in_addr = 32'h401; ld_in_size = 2'd0; ld_in_tag = 4'h7;
        #1;
        total++; if (ld_in_ready !== 1'b0 || dmem_bus.ld_valid !== 1'b0) $display("FAIL incoming_conflict got %b/%b exp 0/0", ld_in_ready, dmem_bus.ld_valid); else passed++;
        step();
        st_in_valid = 1'b0; ld_in_valid = 1'b0;
        total++; if (fwd_valid !== 1'b0 || sb_count !== 3'd1) $display("FAIL incoming_after got %b/%0d exp 0/1", fwd_valid, sb_count); else passed++;
        dmem_bus.st_ready = 1'b1; step(); dmem_bus.st_ready = 1'b0;
    endtask

    task automatic test_full_reset();
        dmem_bus.st_ready = 1'b0;
        for (int i = 0; i < 4; i++) put_store(32'h500 + 32'(8 * i), 64'(i), 8'hFF);
        dmem_bus.st_ready = 1'b1;
        st_in_valid = 1'b1; st_in_addr = 32'h520; st_in_data = 64'h4; st_in_wstrb = 8'hFF;
        #1;
        total++; if (st_in_ready !== 1'b0 || dmem_bus.st_valid !== 1'b1) $display("FAIL full_deq_ready got %b/%b exp 0/1", st_in_ready, dmem_bus.st_valid); else passed++;
        step();
        total++; if (sb_count !== 3'd3 || st_in_ready !== 1'b1) $display("FAIL after_deq got %0d/%b exp 3/1", sb_count, st_in_ready); else passed++;
        step();
        st_in_valid = 1'b0;
        total++; if (sb_count !== 3'd3) $display("FAIL enq_deq_count got %0d exp 3", sb_count); else passed++;
        total++; if (dmem_bus.st_addr !== 32'h510) $display("FAIL wrap_head got %h exp 510", dmem_bus.st_addr); else passed++;
        rst = 1'b1; #1;
        total++; if (dmem_bus.st_valid !== 1'b0) $display("FAIL rst_mid_st_valid got %b exp 0", dmem_bus.st_valid); else passed++;
        step();
        total++; if (sb_count !== 3'd0 || sb_empty !== 1'b1) $display("FAIL rst_mid_count got %0d/%b exp 0/1", sb_count, sb_empty); else passed++;
        rst = 1'b0; #1;
        total++; if (dmem_bus.st_valid !== 1'b0 || st_in_ready !== 1'b1) $display("FAIL rst_mid_rel got %b/%b exp 0/1", dmem_bus.st_valid, st_in_ready); else passed++;
        step(); step();
        total++; if (dmem_bus.st_valid !== 1'b0) $display("FAIL rst_mid_quiet got %b exp 0", dmem_bus.st_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_fifo_drain();
        test_no_conflict();
        test_conflict_stall();
        test_forward();
        test_multi_overlap();
        test_same_cycle_store();
        test_full_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
